up_control_sequencer: RTL

Control and sequencing unit for the 4-bit accumulator microprocessor with 12-bit PC. It alternates FETCH/EXECUTE phases, latches instr/oprnd from program_byte, and decodes the 16 opcodes into PC, ALU, bus, accumulator, RAM and output-port strobes. It also holds the C/Z flag register and resolves conditional jumps. Sits between the program ROM/PC and the datapath (ALU, accu, RAM, IN/OUT buffers).

---
 rtl/up_control_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/up_control_sequencer.sv
// Control and sequencing unit for the 4-bit accumulator CPU: FETCH/EXECUTE
// phasing, instruction latch, opcode decode, C/Z flags and jump resolution.
module up_control_sequencer #(
    parameter int PC_W = 12
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [7:0]      program_byte,
    input  logic            alu_c,
    input  logic            alu_z,
    output logic            phase,
    output logic [3:0]      instr,
    output logic [3:0]      oprnd,
    output logic            c_flag,
    output logic            z_flag,
    output logic            pc_inc,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_target,
    output logic [PC_W-1:0] address_RAM,
    output logic [1:0]      alu_sel,
    output logic [1:0]      bus_src,
    output logic            accu_we,
    output logic            ram_we,
    output logic            out_we
);

    localparam logic [3:0] OP_JC    = 4'b0000;
    localparam logic [3:0] OP_JNC   = 4'b0001;
    localparam logic [3:0] OP_CMPI  = 4'b0010;
    localparam logic [3:0] OP_CMPM  = 4'b0011;
    localparam logic [3:0] OP_LIT   = 4'b0100;
    localparam logic [3:0] OP_IN    = 4'b0101;
    localparam logic [3:0] OP_LD    = 4'b0110;
    localparam logic [3:0] OP_ST    = 4'b0111;
    localparam logic [3:0] OP_JZ    = 4'b1000;
    localparam logic [3:0] OP_JNZ   = 4'b1001;
    localparam logic [3:0] OP_ADDI  = 4'b1010;
    localparam logic [3:0] OP_ADDM  = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_OUT   = 4'b1101;
    localparam logic [3:0] OP_NANDI = 4'b1110;
    localparam logic [3:0] OP_NANDM = 4'b1111;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_ADD  = 2'b10;
    localparam logic [1:0] ALU_NAND = 2'b11;

    localparam logic [1:0] BUS_ACCU = 2'b00;
    localparam logic [1:0] BUS_OPND = 2'b01;
    localparam logic [1:0] BUS_RAM  = 2'b10;
    localparam logic [1:0] BUS_BTN  = 2'b11;

    typedef enum logic {FETCH = 1'b0, EXECUTE = 1'b1} phase_t;

    phase_t     r_phase;
    phase_t     w_phase_next;
    logic [3:0] r_instr;
    logic [3:0] r_oprnd;
    logic       r_c_flag;
    logic       r_z_flag;
    logic       w_flags_we;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase <= FETCH;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_phase_next = (r_phase == FETCH) ? EXECUTE : FETCH;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr <= 4'd0;
            r_oprnd <= 4'd0;
        end else if (r_phase == FETCH) begin
            r_instr <= program_byte[7:4];
            r_oprnd <= program_byte[3:0];
        end
    end

    // Flags only move at the end of an ALU op's EXECUTE; w_flags_we is already gated by phase and reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_c_flag <= 1'b0;
            r_z_flag <= 1'b0;
        end else if (w_flags_we) begin
            r_c_flag <= alu_c;
            r_z_flag <= alu_z;
        end
    end

    // Output decode; everything is held low while reset is asserted
    always_comb begin
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        alu_sel    = ALU_PASS;
        bus_src    = BUS_ACCU;
        accu_we    = 1'b0;
        ram_we     = 1'b0;
        out_we     = 1'b0;
        w_flags_we = 1'b0;
        if (!reset) begin
            if (r_phase == FETCH) begin
                pc_inc = 1'b1;
            end else begin
                unique case (r_instr)
                    OP_JC:    begin pc_load = r_c_flag;  pc_inc = ~r_c_flag; end
                    OP_JNC:   begin pc_load = ~r_c_flag; pc_inc = r_c_flag;  end
                    OP_JZ:    begin pc_load = r_z_flag;  pc_inc = ~r_z_flag; end
                    OP_JNZ:   begin pc_load = ~r_z_flag; pc_inc = r_z_flag;  end
                    OP_JMP:   pc_load = 1'b1;
                    OP_CMPI:  begin bus_src = BUS_OPND; alu_sel = ALU_SUB; w_flags_we = 1'b1; end
                    OP_CMPM:  begin bus_src = BUS_RAM;  alu_sel = ALU_SUB; w_flags_we = 1'b1; pc_inc = 1'b1; end
                    OP_LIT:   begin bus_src = BUS_OPND; accu_we = 1'b1; end
                    OP_IN:    begin bus_src = BUS_BTN;  accu_we = 1'b1; end
                    OP_LD:    begin bus_src = BUS_RAM;  accu_we = 1'b1; pc_inc = 1'b1; end
                    OP_ST:    begin bus_src = BUS_ACCU; ram_we = 1'b1;  pc_inc = 1'b1; end
                    OP_ADDI:  begin bus_src = BUS_OPND; alu_sel = ALU_ADD;  accu_we = 1'b1; w_flags_we = 1'b1; end
                    OP_ADDM:  begin bus_src = BUS_RAM;  alu_sel = ALU_ADD;  accu_we = 1'b1; w_flags_we = 1'b1; pc_inc = 1'b1; end
                    OP_OUT:   begin bus_src = BUS_ACCU; out_we = 1'b1; end
                    OP_NANDI: begin bus_src = BUS_OPND; alu_sel = ALU_NAND; accu_we = 1'b1; w_flags_we = 1'b1; end
                    OP_NANDM: begin bus_src = BUS_RAM;  alu_sel = ALU_NAND; accu_we = 1'b1; w_flags_we = 1'b1; pc_inc = 1'b1; end
                    default:  ;
                endcase
            end
        end
    end

    assign phase       = r_phase;
    assign instr       = r_instr;
    assign oprnd       = r_oprnd;
    assign c_flag      = r_c_flag;
    assign z_flag      = r_z_flag;
    assign pc_target   = {r_oprnd, program_byte};
    assign address_RAM = {r_oprnd, program_byte};

endmodule
